pll_lock_supervisor: RTL and testbench

//  Reset/lock sequencer wrapped around the 27->54 MHz PLL.

---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/pll_lock_supervisor_sync_2ff.sv | 31 +++
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg : state encoding and helpers for the PLL lock supervisor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser, async active-high reset to 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor : PLL reset/lock sequencer with retry and sticky fault
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 27,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_fault,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] C_RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_STABLE_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_TO_LAST     = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic locked_s;

  sync_2ff u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q,  loss_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               fault_q,   fault_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    // Priority inside each state: lock status beats timer expiry.
    case (state_q)
      ST_PLL_RST: begin
        if (timer_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == C_TO_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == C_RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == C_STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // Timer only runs in the timed states and restarts on any transition.
    if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAULT)
      timer_d = '0;
    else
      timer_d = timer_q + 1'b1;

    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor : directed self-checking bench for pll_lock_supervisor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       clear_fault;
  logic       pll_rst;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state;
  logic [1:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (16),
    .LOCK_TIMEOUT_CYCLES (64),
    .MAX_RETRIES         (2),
    .CNT_W               (2)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clear_fault   (clear_fault),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .fault         (fault),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic pr,
                            input logic sr, input logic f, input logic [1:0] cnt);
    check({tag, ".state"},   32'(state),         32'(st));
    check({tag, ".pll_rst"}, 32'(pll_rst),       32'(pr));
    check({tag, ".sys_rst"}, 32'(sys_rst),       32'(sr));
    check({tag, ".fault"},   32'(fault),         32'(f));
    check({tag, ".cnt"},     32'(lock_loss_cnt), 32'(cnt));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check({tag, ".reached"}, 32'(state), 32'(target));
  endtask

  initial begin
    rst         = 1'b1;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;
    repeat (3) tick();
    check_outs("reset", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    #2 rst = 1'b0;

    // Power-up: pll_rst high for cycles 0-3, lock at cycle 10
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("pu.pll_rst_hi", 32'(pll_rst), 32'd1);
    end
    tick();
    check_outs("pu.wait", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (6) tick();
    pll_locked = 1'b1;
    repeat (2) tick();
    check("pu.sync_lat", 32'(state), 32'(ST_WAIT_LOCK));
    tick();
    check("pu.stable", 32'(state), 32'(ST_STABLE));
    repeat (15) tick();
    check_outs("pu.stable_end", ST_STABLE, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_outs("pu.run", ST_RUN, 1'b0, 1'b0, 1'b0, 2'd0);

    // One-cycle lock glitch in RUN
    repeat (3) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("gl.still_run", 32'(state), 32'(ST_RUN));
    tick();
    check_outs("gl.loss", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd1);
    repeat (3) tick();
    check("gl.pll_rst_c4", 32'(pll_rst), 32'd1);
    tick();
    check_outs("gl.wait", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    check("gl.stable", 32'(state), 32'(ST_STABLE));
    repeat (15) tick();
    check("gl.sys_rst_held", 32'(sys_rst), 32'd1);
    tick();
    check_outs("gl.run", ST_RUN, 1'b0, 1'b0, 1'b0, 2'd1);

    // Lock never asserts: two timeouts then FAULT
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    check_outs("to.rst", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    #2 rst = 1'b0;
    repeat (4) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("to.clear_ignored", 32'(state), 32'(ST_WAIT_LOCK));
    repeat (62) tick();
    check("to.wait63", 32'(state), 32'(ST_WAIT_LOCK));
    tick();
    check_outs("to.retry1", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    repeat (67) tick();
    check("to.wait2", 32'(state), 32'(ST_WAIT_LOCK));
    tick();
    check_outs("to.fault", ST_FAULT, 1'b1, 1'b1, 1'b1, 2'd0);
    repeat (5) tick();
    check_outs("to.fault_hold", ST_FAULT, 1'b1, 1'b1, 1'b1, 2'd0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_outs("to.cleared", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    repeat (67) tick();
    check("to.retry_clr_wait", 32'(state), 32'(ST_WAIT_LOCK));
    tick();
    check_outs("to.retry_clr", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);

    // Lock drops on last STABLE cycle; retry_cnt stays at 1
    pll_locked = 1'b1;
    repeat (5) tick();
    check("sd.stable", 32'(state), 32'(ST_STABLE));
    repeat (13) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    check("sd.stable15", 32'(state), 32'(ST_STABLE));
    tick();
    check_outs("sd.drop", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (63) tick();
    check("sd.wait63", 32'(state), 32'(ST_WAIT_LOCK));
    tick();
    check_outs("sd.fault", ST_FAULT, 1'b1, 1'b1, 1'b1, 2'd0);

    // Five lock losses from RUN; counter saturates at 3
    pll_locked  = 1'b1;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wait_state("sat.run", ST_RUN, 100);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (2) tick();
      check("sat.state", 32'(state), 32'(ST_PLL_RST));
      check("sat.cnt", 32'(lock_loss_cnt), (i < 3) ? i : 3);
    end

    // Asynchronous reset mid-STABLE and mid-RUN
    wait_state("ar.stable", ST_STABLE, 100);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 check_outs("ar.stable", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    #2 rst = 1'b0;
    wait_state("ar.run", ST_RUN, 100);
    repeat (2) tick();
    check("ar.pre_run", 32'(sys_rst), 32'd0);
    #2 rst = 1'b1;
    #1 check_outs("ar.run", ST_PLL_RST, 1'b1, 1'b1, 1'b0, 2'd0);
    #2 rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
